// File: rtl/apu_sequencer_gen3_if.sv
// CPU-side bus of the APU control core.
// Signals:
//   cpu_clk  - one-clk enable per CPU cycle; bus accesses count only when high
//   a_in     - CPU address
//   from_cpu - CPU write data
//   r_nw     - 1 = read, 0 = write
//   to_cpu   - status read data returned to the CPU
// Modports: master = CPU side, slave = APU core side.
interface apu_sequencer_gen3_if;
  logic        cpu_clk;
  logic [15:0] a_in;
  logic [7:0]  from_cpu;
  logic        r_nw;
  logic [7:0]  to_cpu;

  modport master (output cpu_clk, a_in, from_cpu, r_nw, input  to_cpu);
  modport slave  (input  cpu_clk, a_in, from_cpu, r_nw, output to_cpu);
endinterface

// File: rtl/apu_sequencer_gen3.sv
// APU control core: $4015 channel enable/status, $4017 frame sequencer and
// frame IRQ with 4-step/5-step modes, IRQ inhibit, DMC IRQ merge and the
// delayed frame-counter reset that follows a $4017 write.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   bus        - CPU bus (cpu_clk enable, address, data, r_nw, to_cpu)
//   ch_active  - per-channel "length counter non-zero"
//   dmc_irq    - DMC IRQ flag, merged into irq and status bit 7
//   ch_en      - channel enables written through $4015
//   apu_clk    - enable on every second cpu_clk
//   e_pulse    - quarter-frame enable, one clk wide
//   l_pulse    - half-frame enable, one clk wide
//   irq        - frame_irq | dmc_irq
module apu_sequencer_gen3 #(
  parameter int NUM_CH  = 5,
  parameter int CNT_W   = 16,
  parameter int STEP1   = 7457,
  parameter int STEP2   = 14913,
  parameter int STEP3   = 22371,
  parameter int STEP4_4 = 29829,
  parameter int STEP4_5 = 37281
) (
  input  logic                 clk,
  input  logic                 rst,
  apu_sequencer_gen3_if.slave  bus,
  input  logic [NUM_CH-1:0]    ch_active,
  input  logic                 dmc_irq,
  output logic [NUM_CH-1:0]    ch_en,
  output logic                 apu_clk,
  output logic                 e_pulse,
  output logic                 l_pulse,
  output logic                 irq
);

  localparam logic [CNT_W-1:0] S1   = CNT_W'(STEP1);
  localparam logic [CNT_W-1:0] S2   = CNT_W'(STEP2);
  localparam logic [CNT_W-1:0] S3   = CNT_W'(STEP3);
  localparam logic [CNT_W-1:0] S44  = CNT_W'(STEP4_4);
  localparam logic [CNT_W-1:0] S45  = CNT_W'(STEP4_5);
  localparam logic [CNT_W-1:0] W4   = CNT_W'(STEP4_4 + 1);
  localparam logic [CNT_W-1:0] W5   = CNT_W'(STEP4_5 + 1);
  localparam logic [CNT_W-1:0] I_LO = CNT_W'(STEP4_4 - 1);

  typedef enum logic {IDLE, PEND} dly_st_t;

  dly_st_t          st, st_nxt;
  logic [2:0]       dly, dly_nxt;
  logic             fire;
  logic             phase, mode, inhibit, frame_irq;
  logic [CNT_W-1:0] count;
  logic             cpu_clk, rd_sel, rd_4015, wr_4015, wr_4017;
  logic             hit_e, hit_l, wrap, irq_set;
  logic [4:0]       act5;

  assign cpu_clk = bus.cpu_clk;
  assign rd_sel  = bus.r_nw && (bus.a_in == 16'h4015);
  assign rd_4015 = cpu_clk && rd_sel;
  assign wr_4015 = cpu_clk && !bus.r_nw && (bus.a_in == 16'h4015);
  assign wr_4017 = cpu_clk && !bus.r_nw && (bus.a_in == 16'h4017);

  // Delayed counter reset: the write loads the number of remaining cpu_clks
  // (3 when phase=1, 4 otherwise); fire marks the clk on which it lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      dly <= 3'd0;
    end else begin
      st  <= st_nxt;
      dly <= dly_nxt;
    end
  end

  always_comb begin
    st_nxt  = st;
    dly_nxt = dly;
    fire    = 1'b0;
    if (cpu_clk) begin
      if (wr_4017) begin
        // A new write restarts the delay even if one is already pending.
        st_nxt  = PEND;
        dly_nxt = phase ? 3'd3 : 3'd4;
      end else if (st == PEND) begin
        if (dly == 3'd1) begin
          fire    = 1'b1;
          st_nxt  = IDLE;
          dly_nxt = 3'd0;
        end else begin
          dly_nxt = dly - 3'd1;
        end
      end
    end
  end

  // Step comparisons use the already-latched mode, so a mode change takes
  // effect on comparisons right away while the count reset waits.
  always_comb begin
    hit_e   = (count == S1) || (count == S2) || (count == S3);
    hit_l   = (count == S2);
    wrap    = 1'b0;
    irq_set = 1'b0;
    if (mode) begin
      hit_e = hit_e || (count == S45);
      hit_l = hit_l || (count == S45);
      wrap  = (count >= W5);
    end else begin
      hit_e   = hit_e || (count == S44);
      hit_l   = hit_l || (count == S44);
      wrap    = (count >= W4);
      irq_set = !inhibit && (count >= I_LO) && (count <= W4);
    end
    if (fire && mode) begin
      hit_e = 1'b1;
      hit_l = 1'b1;
    end
  end

  assign e_pulse = !rst && cpu_clk && hit_e;
  assign l_pulse = !rst && cpu_clk && hit_l;
  assign apu_clk = cpu_clk && phase;
  assign irq     = frame_irq || dmc_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= 1'b0;
      mode      <= 1'b0;
      inhibit   <= 1'b0;
      frame_irq <= 1'b0;
      count     <= '0;
      ch_en     <= '0;
    end else if (cpu_clk) begin
      phase <= !phase;
      if (fire || wrap) count <= '0;
      else              count <= count + CNT_W'(1);
      if (wr_4015) ch_en <= bus.from_cpu[NUM_CH-1:0];
      if (wr_4017) begin
        mode    <= bus.from_cpu[7];
        inhibit <= bus.from_cpu[6];
      end
      // Inhibit clears outright; otherwise a set beats a status-read clear.
      if (wr_4017 && bus.from_cpu[6]) frame_irq <= 1'b0;
      else if (irq_set)                frame_irq <= 1'b1;
      else if (rd_4015)                frame_irq <= 1'b0;
    end
  end

  // Status read is combinational while the $4015 read is presented.
  always_comb begin
    act5               = 5'd0;
    act5[NUM_CH-1:0]   = ch_active;
    bus.to_cpu         = 8'h00;
    if (rd_sel) bus.to_cpu = {dmc_irq, frame_irq, 1'b0, act5};
  end

endmodule

// File: tb/tb_apu_sequencer_gen3.sv
module tb_apu_sequencer_gen3;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, cpu_clk, r_nw, dmc_irq;
  logic [15:0] a_in;
  logic [7:0]  from_cpu;
  logic [4:0]  ch_active;

  apu_sequencer_gen3_if bus_a();
  apu_sequencer_gen3_if bus_b();
  apu_sequencer_gen3_if bus_s();

  assign bus_a.cpu_clk = cpu_clk; assign bus_a.a_in = a_in;
  assign bus_a.from_cpu = from_cpu; assign bus_a.r_nw = r_nw;
  assign bus_b.cpu_clk = cpu_clk; assign bus_b.a_in = a_in;
  assign bus_b.from_cpu = from_cpu; assign bus_b.r_nw = r_nw;
  assign bus_s.cpu_clk = cpu_clk; assign bus_s.a_in = a_in;
  assign bus_s.from_cpu = from_cpu; assign bus_s.r_nw = r_nw;

  logic [4:0] ch_en_a, ch_en_s;
  logic [1:0] ch_en_b;
  logic apu_clk_a, e_a, l_a, irq_a;
  logic apu_clk_b, e_b, l_b, irq_b;
  logic apu_clk_s, e_s, l_s, irq_s;

  apu_sequencer_gen3 dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .ch_active(ch_active), .dmc_irq(dmc_irq),
    .ch_en(ch_en_a), .apu_clk(apu_clk_a), .e_pulse(e_a), .l_pulse(l_a), .irq(irq_a));

  apu_sequencer_gen3 #(.NUM_CH(2)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .ch_active(ch_active[1:0]), .dmc_irq(dmc_irq),
    .ch_en(ch_en_b), .apu_clk(apu_clk_b), .e_pulse(e_b), .l_pulse(l_b), .irq(irq_b));

  // Short step values so the multi-cycle corner cases fit in a few dozen cycles.
  apu_sequencer_gen3 #(.NUM_CH(5), .CNT_W(8), .STEP1(4), .STEP2(8), .STEP3(12),
                       .STEP4_4(16), .STEP4_5(20)) dut_s (
    .clk(clk), .rst(rst), .bus(bus_s), .ch_active(ch_active), .dmc_irq(dmc_irq),
    .ch_en(ch_en_s), .apu_clk(apu_clk_s), .e_pulse(e_s), .l_pulse(l_s), .irq(irq_s));

  localparam int P_ELI_A = 0, P_TO_A = 1, P_EN_A = 2, P_TO_B = 3, P_EN_B = 4,
                 P_ELI_S = 5, P_TO_S = 6;

  typedef struct {
    int         sig;
    logic [7:0] exp;
    string      nm;
  } sb_t;
  sb_t sbq[$];

  int total = 0;
  int bad   = 0;

  function automatic logic [7:0] probe(int sig);
    case (sig)
      P_ELI_A: probe = {4'b0, apu_clk_a, e_a, l_a, irq_a};
      P_TO_A:  probe = bus_a.to_cpu;
      P_EN_A:  probe = {3'b0, ch_en_a};
      P_TO_B:  probe = bus_b.to_cpu;
      P_EN_B:  probe = {6'b0, ch_en_b};
      P_ELI_S: probe = {4'b0, apu_clk_s, e_s, l_s, irq_s};
      P_TO_S:  probe = bus_s.to_cpu;
      default: probe = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] eli(bit ap, bit e, bit l, bit q);
    return {4'b0, ap, e, l, q};
  endfunction

  // Expected pulses of dut_s from its own count and mode.
  function automatic bit se(int c, bit m5);
    return c == 4 || c == 8 || c == 12 || (!m5 && c == 16) || (m5 && c == 20);
  endfunction
  function automatic bit sl(int c, bit m5);
    return c == 8 || (!m5 && c == 16) || (m5 && c == 20);
  endfunction

  task automatic push(int sig, logic [7:0] exp, string nm);
    sb_t t;
    t.sig = sig; t.exp = exp; t.nm = nm;
    sbq.push_back(t);
  endtask

  // Drive one clk of stimulus, compare everything queued for it at the
  // falling edge, then advance past the next rising edge.
  task automatic step(bit cpu, bit rnw, logic [15:0] a, logic [7:0] d);
    sb_t t;
    logic [7:0] got;
    cpu_clk = cpu; r_nw = rnw; a_in = a; from_cpu = d;
    @(negedge clk);
    while (sbq.size() > 0) begin
      t = sbq.pop_front();
      got = probe(t.sig);
      total++;
      if (got !== t.exp) begin
        bad++;
        $display("FAIL %s: got %02h expected %02h at %0t", t.nm, got, t.exp, $time);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b1, 16'h0000, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b1, 16'h0000, 8'h00);
    step(1'b0, 1'b1, 16'h0000, 8'h00);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         cpu;
    bit         rnw;
    logic [15:0] addr;
    logic [7:0] data;
    logic [4:0] act;
    bit         dmc;
    logic [7:0] to_a;
    logic [4:0] en_a;
    logic [7:0] to_b;
    logic [1:0] en_b;
  } vec_t;

  initial begin
    vec_t vt[9];
    bit ph;
    bit e, l, q, m5;
    int c;

    vt[0] = '{1, 0, 16'h4015, 8'h1F, 5'b10101, 0, 8'h00, 5'h00, 8'h00, 2'b00};
    vt[1] = '{1, 1, 16'h4015, 8'h00, 5'b10101, 0, 8'h15, 5'h1F, 8'h01, 2'b11};
    vt[2] = '{1, 1, 16'h4014, 8'h00, 5'b10101, 0, 8'h00, 5'h1F, 8'h00, 2'b11};
    vt[3] = '{1, 0, 16'h4015, 8'h0A, 5'b10101, 0, 8'h00, 5'h1F, 8'h00, 2'b11};
    vt[4] = '{1, 1, 16'h4015, 8'h00, 5'b11111, 1, 8'h9F, 5'h0A, 8'h83, 2'b10};
    vt[5] = '{1, 0, 16'h4015, 8'hE0, 5'b00000, 0, 8'h00, 5'h0A, 8'h00, 2'b10};
    vt[6] = '{1, 1, 16'h4015, 8'h00, 5'b00011, 0, 8'h03, 5'h00, 8'h03, 2'b00};
    vt[7] = '{0, 0, 16'h4015, 8'h1F, 5'b00000, 0, 8'h00, 5'h00, 8'h00, 2'b00};
    vt[8] = '{1, 1, 16'h4015, 8'h00, 5'b00000, 0, 8'h00, 5'h00, 8'h00, 2'b00};

    rst = 1'b1; cpu_clk = 1'b0; r_nw = 1'b1; a_in = 16'h0; from_cpu = 8'h0;
    ch_active = 5'b0; dmc_irq = 1'b0;
    @(posedge clk); #1;

    // Reset state, with a status read presented while cpu_clk is low.
    do_reset();
    push(P_ELI_A, eli(0, 0, 0, 0), "reset.eli_a");
    push(P_EN_A, 8'h00, "reset.ch_en_a");
    push(P_TO_A, 8'h00, "reset.to_cpu_a");
    push(P_ELI_S, eli(0, 0, 0, 0), "reset.eli_s");
    step(1'b0, 1'b1, 16'h4015, 8'h00);

    // Full 4-step frame from reset; status reads at 29829 and 29835.
    for (int k = 0; k <= 29836; k++) begin
      bit rd;
      rd = (k == 29829) || (k == 29835);
      e  = (k == 7457) || (k == 14913) || (k == 22371) || (k == 29829);
      l  = (k == 14913) || (k == 29829);
      q  = (k >= 29829) && (k <= 29835);
      push(P_ELI_A, eli(bit'(k % 2), e, l, q), $sformatf("frame4.eli k=%0d", k));
      if (rd) push(P_TO_A, 8'h40, $sformatf("frame4.status k=%0d", k));
      step(1'b1, 1'b1, rd ? 16'h4015 : 16'h0000, 8'h00);
    end

    // $4015 register table, also against the 2-channel instance.
    do_reset();
    ph = 1'b0;
    for (int i = 0; i < 9; i++) begin
      ch_active = vt[i].act;
      dmc_irq   = vt[i].dmc;
      push(P_TO_A, vt[i].to_a, $sformatf("tbl%0d.to_cpu_a", i));
      push(P_EN_A, {3'b0, vt[i].en_a}, $sformatf("tbl%0d.ch_en_a", i));
      push(P_TO_B, vt[i].to_b, $sformatf("tbl%0d.to_cpu_b", i));
      push(P_EN_B, {6'b0, vt[i].en_b}, $sformatf("tbl%0d.ch_en_b", i));
      push(P_ELI_A, eli(vt[i].cpu & ph, 0, 0, vt[i].dmc), $sformatf("tbl%0d.eli_a", i));
      step(vt[i].cpu, vt[i].rnw, vt[i].addr, vt[i].data);
      if (vt[i].cpu) ph = ~ph;
    end
    ch_active = 5'b0; dmc_irq = 1'b0;

    // Inhibit with IRQ pending, then DMC IRQ merge (short-step instance).
    do_reset();
    for (int k = 0; k <= 61; k++) begin
      c = (k <= 17) ? k : ((k <= 20) ? k - 18 : (k - 21) % 18);
      dmc_irq = (k == 61);
      q = (k == 16) || (k == 61);
      push(P_ELI_S, eli(bit'(k % 2), se(c, 0), sl(c, 0), q), $sformatf("inhibit.eli k=%0d", k));
      if (k == 61) push(P_TO_S, 8'h80, "inhibit.dmc_status");
      if (k == 16)      step(1'b1, 1'b0, 16'h4017, 8'h40);
      else if (k == 61) step(1'b1, 1'b1, 16'h4015, 8'h00);
      else              idle();
    end
    dmc_irq = 1'b0;

    // 5-step write at phase=1: reset lands on the 3rd cpu_clk with e and l.
    do_reset();
    for (int k = 0; k <= 60; k++) begin
      c  = (k <= 6) ? k : (k - 7) % 22;
      m5 = (k >= 4);
      e  = (k == 6) || se(c, m5);
      l  = (k == 6) || sl(c, m5);
      push(P_ELI_S, eli(bit'(k % 2), e, l, 0), $sformatf("five_ph1.eli k=%0d", k));
      if (k == 3) step(1'b1, 1'b0, 16'h4017, 8'h80);
      else        idle();
    end

    // Second write during the delay restarts it with 4-step values.
    do_reset();
    for (int k = 0; k <= 30; k++) begin
      c  = (k <= 6) ? k : (k - 7) % 18;
      m5 = (k >= 1) && (k <= 2);
      push(P_ELI_S, eli(bit'(k % 2), se(c, m5), sl(c, m5), k >= 23),
           $sformatf("restart.eli k=%0d", k));
      if (k == 0)      step(1'b1, 1'b0, 16'h4017, 8'h80);
      else if (k == 2) step(1'b1, 1'b0, 16'h4017, 8'h00);
      else             idle();
    end

    // Mode switch to 5-step just before the 4-step end count.
    do_reset();
    for (int k = 0; k <= 30; k++) begin
      c  = (k <= 18) ? k : (k - 19) % 22;
      m5 = (k >= 15);
      e  = (k == 18) || se(c, m5);
      l  = (k == 18) || sl(c, m5);
      push(P_ELI_S, eli(bit'(k % 2), e, l, 0), $sformatf("modesw.eli k=%0d", k));
      if (k == 14) step(1'b1, 1'b0, 16'h4017, 8'h80);
      else         idle();
    end

    // Reset during the delay; afterwards cpu_clk only every other clk.
    do_reset();
    step(1'b1, 1'b0, 16'h4017, 8'h80);
    idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    for (int j = 0; j <= 20; j++) begin
      push(P_ELI_S, eli(0, 0, 0, j >= 16), $sformatf("rstdly.gap j=%0d", j));
      step(1'b0, 1'b1, 16'h0000, 8'h00);
      push(P_ELI_S, eli(bit'(j % 2), se(j, 0), sl(j, 0), j >= 16), $sformatf("rstdly.eli j=%0d", j));
      idle();
    end

    // 5-step write at phase=0 on the full-size instance; no IRQ ever.
    do_reset();
    for (int k = 0; k <= 40004; k++) begin
      if (k < 5) begin
        e = (k == 4); l = (k == 4);
      end else begin
        c = (k - 5) % 37282;
        e = (c == 7457) || (c == 14913) || (c == 22371) || (c == 37281);
        l = (c == 14913) || (c == 37281);
      end
      push(P_ELI_A, eli(bit'(k % 2), e, l, 0), $sformatf("frame5.eli k=%0d", k));
      if (k == 0) step(1'b1, 1'b0, 16'h4017, 8'h80);
      else        idle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
